// File: rtl/signed_seg_display.sv
// Shows a latched 4-bit two's-complement value in sign-magnitude form on a
// 4-digit common-anode display. Define SIGNED_SEG_RAW_HEX_EN to show the raw hex pattern on DIG3.
module signed_seg_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] value,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b0111111;

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} scan_state_t;

  scan_state_t   scan_state;
  logic [3:0]    held;
  logic [CW-1:0] cnt;
  logic          neg;
  logic [3:0]    mag;

  // Active-low gfedcba glyphs; hex letters exist only when the raw view is built.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    g = BLANK;
    case (d)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
`ifdef SIGNED_SEG_RAW_HEX_EN
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      4'hF: g = 7'b0001110;
`endif
      default: g = BLANK;
    endcase
    return g;
  endfunction

  // 4-bit negate of -8 wraps back to 4'b1000, which reads correctly as magnitude 8.
  always_comb begin
    neg = held[3];
    mag = neg ? (~held + 4'd1) : held;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      held       <= 4'd0;
      cnt        <= '0;
      scan_state <= DIG0;
      an         <= 4'b1111;
      seg        <= BLANK;
      dp         <= 1'b1;
    end else begin
      if (load) held <= value;

      if (cnt == LAST) begin
        cnt <= '0;
        case (scan_state)
          DIG0:    scan_state <= DIG1;
          DIG1:    scan_state <= DIG2;
          DIG2:    scan_state <= DIG3;
          default: scan_state <= DIG0;
        endcase
      end else begin
        cnt <= cnt + CW'(1);
      end

      // Outputs follow the current (pre-update) state, so they trail it by one cycle.
      dp <= 1'b1;
      case (scan_state)
        DIG0: begin
          an  <= 4'b1110;
          seg <= glyph(mag);
        end
        DIG1: begin
          an  <= 4'b1101;
          seg <= neg ? MINUS : BLANK;
        end
        DIG2: begin
          an  <= 4'b1011;
          seg <= BLANK;
        end
        default: begin
          an  <= 4'b0111;
`ifdef SIGNED_SEG_RAW_HEX_EN
          seg <= glyph(held);
`else
          seg <= BLANK;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_seg_display.sv
// Directed bench for signed_seg_display with REFRESH_DIV=4: vector table per
// value plus hand-written sequences for reset, capture latency and wrap/reset collisions.
module tb_signed_seg_display;

  localparam int DIV = 4;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b0111111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [3:0] value = 4'd0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];

  typedef struct {
    logic [3:0] v;
    logic [6:0] dig0;
    logic [6:0] dig1;
    logic [6:0] dig3;
  } vec_t;

  vec_t vecs[6];

  signed_seg_display #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value),
    .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [3:0] exp_an, input logic [6:0] exp_seg);
    checks++;
    if (an !== exp_an || seg !== exp_seg || dp !== 1'b1) begin
      errors++;
      $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=1",
               name, an, seg, dp, exp_an, exp_seg);
    end
  endtask

  task automatic chk_an(input string name);
    logic [3:0] e;
    e = exp_q.pop_front();
    checks++;
    if (an !== e) begin
      errors++;
      $display("FAIL %s: got an=%b, expected an=%b", name, an, e);
    end
  endtask

  initial begin
`ifdef SIGNED_SEG_RAW_HEX_EN
    vecs[0] = '{4'b0000, 7'b1000000, BLANK, 7'b1000000};
    vecs[1] = '{4'b0101, 7'b0010010, BLANK, 7'b0010010};
    vecs[2] = '{4'b1101, 7'b0110000, MINUS, 7'b0100001};
    vecs[3] = '{4'b1000, 7'b0000000, MINUS, 7'b0000000};
    vecs[4] = '{4'b0111, 7'b1111000, BLANK, 7'b1111000};
    vecs[5] = '{4'b1111, 7'b1111001, MINUS, 7'b0001110};
`else
    vecs[0] = '{4'b0000, 7'b1000000, BLANK, BLANK};
    vecs[1] = '{4'b0101, 7'b0010010, BLANK, BLANK};
    vecs[2] = '{4'b1101, 7'b0110000, MINUS, BLANK};
    vecs[3] = '{4'b1000, 7'b0000000, MINUS, BLANK};
    vecs[4] = '{4'b0111, 7'b1111000, BLANK, BLANK};
    vecs[5] = '{4'b1111, 7'b1111001, MINUS, BLANK};
`endif

    // Reset held 3 cycles, then first cycle after release and 1-cycle capture latency.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("reset_hold", 4'b1111, BLANK);
    end
    reset = 1'b0;
    tick(1);
    chk("first_after_reset", 4'b1110, 7'b1000000);
    load = 1'b1; value = 4'b0101;
    tick(1);
    chk("capture_edge_old_value", 4'b1110, 7'b1000000);
    load = 1'b0;
    tick(1);
    chk("capture_latency_1", 4'b1110, 7'b0010010);

    // Vector table: reset, load, then visit each digit phase.
    for (int k = 0; k < 6; k++) begin
      reset = 1'b1;
      tick(1);
      chk($sformatf("vec%0d_reset", k), 4'b1111, BLANK);
      reset = 1'b0; load = 1'b1; value = vecs[k].v;
      tick(1);
      load = 1'b0;
      tick(1);
      chk($sformatf("vec%0d_dig0", k), 4'b1110, vecs[k].dig0);
      tick(3);
      chk($sformatf("vec%0d_dig1", k), 4'b1101, vecs[k].dig1);
      tick(4);
      chk($sformatf("vec%0d_dig2", k), 4'b1011, BLANK);
      tick(4);
      chk($sformatf("vec%0d_dig3", k), 4'b0111, vecs[k].dig3);
    end

    // Free run: each anode pattern held exactly DIV cycles, then repeats.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      case ((i / DIV) % 4)
        0: exp_q.push_back(4'b1110);
        1: exp_q.push_back(4'b1101);
        2: exp_q.push_back(4'b1011);
        default: exp_q.push_back(4'b0111);
      endcase
    end
    for (int i = 0; i < 17; i++) begin
      tick(1);
      chk_an($sformatf("free_run_c%0d", i));
    end

    // Load on the DIG0->DIG1 wrap edge: next cycle shows DIG1 with the new value.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(3);
    load = 1'b1; value = 4'b1101;
    tick(1);
    chk("wrap_load_edge", 4'b1110, 7'b1000000);
    load = 1'b0;
    tick(1);
    chk("wrap_load_dig1", 4'b1101, MINUS);
    tick(12);
    chk("wrap_load_dig0", 4'b1110, 7'b0110000);

    // Reset mid-DIG2 with load asserted: load ignored, scan restarts at DIG0.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(10);
    chk("mid_dig2", 4'b1011, BLANK);
    reset = 1'b1; load = 1'b1; value = 4'b0111;
    tick(1);
    chk("mid_reset_dark", 4'b1111, BLANK);
    reset = 1'b0; load = 1'b0;
    tick(1);
    chk("mid_reset_restart", 4'b1110, 7'b1000000);
    tick(3);
    chk("mid_reset_dig0_last", 4'b1110, 7'b1000000);
    tick(1);
    chk("mid_reset_dig1", 4'b1101, BLANK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/signed_seg_display.md
Name: signed_seg_display

Overview:
- Downstream consumer of the 4-bit two's-complement negation stage: latches a 4-bit signed result and shows it in sign-magnitude form on the board's 4-digit, common-anode 7-segment display.
- Time-multiplexes the four digits with a refresh counter and a digit-scan state machine.
- Digit 0 (rightmost) shows the magnitude, digit 1 shows the sign, and digits 2 and 3 are blank unless the optional feature is enabled.

Parameters:
- REFRESH_DIV, 100000, clock cycles each digit stays active; legal range 2..2^20.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  capture strobe; value is sampled on any rising edge with load=1.
- value  input  4  two's-complement operand (-8..+7), e.g. the output of the negation stage.
- seg  output  7  segment cathodes, active-low, bit order {g,f,e,d,c,b,a}; registered.
- an  output  4  digit anodes, active-low, an[0] = rightmost digit; registered.
- dp  output  1  decimal point, active-low; constant 1 (off) out of reset.

Behaviour:
- Reset, sampled on the rising edge with reset=1:
  - Held value register = 0.
  - Refresh counter = 0.
  - Scan state = DIG0.
  - an = 4'b1111, seg = 7'b1111111, dp = 1.
  - load is ignored while reset=1.
- Capture:
  - On an edge with load=1 and reset=0, the held register takes value.
  - The held value is unchanged otherwise.
  - The new value drives seg starting from the next edge on which the corresponding digit is active.
  - Capture latency is 1 cycle when that digit is already active.
- Magnitude and sign:
  - neg = held[3].
  - mag = neg ? (~held + 1) : held, computed 4 bits wide with no truncation: -8 gives mag = 8.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - On the wrap edge, the scan state advances.
- Scan FSM:
  - Order is DIG0 -> DIG1 -> DIG2 -> DIG3 -> DIG0, one state per REFRESH_DIV cycles.
  - Output registers update every cycle from the current state.
  - an is one-hot low for the current digit: DIG0 = 1110, DIG1 = 1101, DIG2 = 1011, DIG3 = 0111.
  - Because outputs are registered, an and seg lag the state by 1 cycle.
- Digit contents:
  - DIG0: decimal glyph for mag, 0..8.
  - DIG1: minus (7'b0111111) if neg, else blank.
  - DIG2: blank.
  - DIG3: blank.
- Glyphs (gfedcba, active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000
  - blank = 1111111, minus = 0111111
- Simultaneous events:
  - load on the same edge as a digit change: both take effect. The state advances and the held value updates, and the next cycle's outputs use the new state and the new value.
  - Reset mid-scan: reset has priority over load and over the counter. The display returns to DIG0 with all digits dark for the reset cycle. The first cycle after reset drives an = 1110.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: SIGNED_SEG_RAW_HEX_EN.
- Defined: DIG3 shows the raw held bit pattern as a hex glyph. The additional glyphs are:
  - 9 = 0010000, A = 0001000, b = 0000011, C = 1000110
  - d = 0100001, E = 0000110, F = 0001110
- Not defined: DIG3 is always blank, and the hex glyph table is not synthesised.

Test Plan (REFRESH_DIV=4):
- Reset held 3 cycles, then released -> during reset an = 1111, seg = 1111111; first cycle after release an = 1110, seg = 1000000 (0).
- load with value = 4'b0101 -> DIG0 shows 0010010 (5); DIG1 phase shows an = 1101, seg = 1111111.
- load with value = 4'b1101 (-3) -> DIG0 shows 0110000 (3); DIG1 phase shows seg = 0111111.
- load with value = 4'b1000 (-8) -> DIG0 shows 0000000 (8) and DIG1 shows minus, with no wrap to 0.
- Free run for 16 cycles -> an sequence 1110, 1101, 1011, 0111, each held exactly 4 cycles, then repeats.
- load asserted on a digit-wrap edge, and separately reset asserted mid-DIG2 -> the new value appears when its digit is next active; reset forces an = 1111 for the reset cycle and restarts the scan at DIG0.
- With SIGNED_SEG_RAW_HEX_EN defined and value = 4'b1101 -> the DIG3 phase shows an = 0111, seg = 0100001 (d).
